// File: rtl/alu_issue_stage.sv
// alu_issue_stage: issue/capture stage in front of the 32-bit ALU.
// Builds ALU operands (register or extended immediate, with single-entry
// forwarding from the result register), holds them for multi-cycle mul/div,
// and captures the ALU result into a valid/ready output register.
//
// Handshake semantics (both sides): a transfer happens on a rising edge where
// valid && ready are both high. A producer keeps valid and its payload stable
// until the transfer; ready may change freely. in_ready is combinational from
// the FSM state and the result register only, never from in_valid.
module alu_issue_stage #(
    parameter int MULDIV_LAT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [4:0]  in_op,
    input  logic [4:0]  in_rs,
    input  logic [4:0]  in_rt,
    input  logic [31:0] in_rs_val,
    input  logic [31:0] in_rt_val,
    input  logic [15:0] in_imm,
    input  logic        in_use_imm,
    input  logic        in_imm_signed,
    input  logic [4:0]  in_rd,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [4:0]  alu_sel,
    input  logic [31:0] alu_out,
    input  logic        alu_carry,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic        out_carry,
    output logic [4:0]  out_rd,
    output logic [1:0]  dbg_state
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_EXEC   = 2'd1;
    localparam logic [1:0] ST_MULDIV = 2'd2;

    localparam logic [4:0] OP_MUL = 5'b00010;
    localparam logic [4:0] OP_DIV = 5'b00011;

    // Counter is loaded with LAT-1 so capture lands exactly LAT cycles
    // after the operands first appear on the ALU.
    localparam logic [3:0] CNT_LOAD = 4'(MULDIV_LAT - 1);

    logic [1:0]  state;
    logic [3:0]  cnt;
    logic [4:0]  rd_q;
    logic        div_zero_q;

    logic        accept;
    logic        capture;
    logic [31:0] fwd_a;
    logic [31:0] fwd_b;
    logic [31:0] ext_imm;
    logic [31:0] sel_b;
    logic        is_muldiv;
    logic        div_zero;

    // Handshake and operand construction for the operation on the input port.
    always_comb begin
        in_ready  = (state == ST_IDLE) && (!out_valid || out_ready);
        accept    = in_valid && in_ready;

        // Forwarding uses the held result even while it is draining this
        // cycle; register 0 is never forwarded.
        fwd_a = in_rs_val;
        if (out_valid && (out_rd == in_rs) && (in_rs != 5'd0)) begin
            fwd_a = out_result;
        end
        fwd_b = in_rt_val;
        if (out_valid && (out_rd == in_rt) && (in_rt != 5'd0)) begin
            fwd_b = out_result;
        end

        ext_imm = in_imm_signed ? {{16{in_imm[15]}}, in_imm} : {16'b0, in_imm};
        sel_b   = in_use_imm ? ext_imm : fwd_b;

        // A divide with a zero divisor never waits for the ALU.
        div_zero  = (in_op == OP_DIV) && (sel_b == 32'd0);
        is_muldiv = ((in_op == OP_MUL) || (in_op == OP_DIV)) && !div_zero;

        capture = (state == ST_EXEC) || ((state == ST_MULDIV) && (cnt == 4'd0));
        dbg_state = state;
    end

    // FSM, latency counter and the ALU operand registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            cnt        <= 4'd0;
            alu_a      <= 32'd0;
            alu_b      <= 32'd0;
            alu_sel    <= 5'd0;
            rd_q       <= 5'd0;
            div_zero_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        alu_sel    <= in_op;
                        alu_a      <= fwd_a;
                        alu_b      <= sel_b;
                        rd_q       <= in_rd;
                        div_zero_q <= div_zero;
                        if (is_muldiv) begin
                            state <= ST_MULDIV;
                            cnt   <= CNT_LOAD;
                        end else begin
                            state <= ST_EXEC;
                        end
                    end
                end
                ST_EXEC: begin
                    state <= ST_IDLE;
                end
                ST_MULDIV: begin
                    if (cnt == 4'd0) begin
                        state <= ST_IDLE;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Result register: capture wins over a drain on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_result <= 32'd0;
            out_carry  <= 1'b0;
            out_rd     <= 5'd0;
        end else if (capture) begin
            out_valid  <= 1'b1;
            out_result <= div_zero_q ? 32'hFFFF_FFFF : alu_out;
            out_carry  <= div_zero_q ? 1'b0 : alu_carry;
            out_rd     <= rd_q;
        end else if (out_valid && out_ready) begin
            out_valid  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Testbench for alu_issue_stage: behavioural ALU, directed vector table,
// hand-written multi-cycle sequences, and a randomized phase scored against
// a transaction-level model of the stage.
module tb_alu_issue_stage;

    localparam int LAT = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1, "timeout");
    end

    // ---------------- DUT ----------------
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [4:0]  in_op = '0, in_rs = '0, in_rt = '0, in_rd = '0;
    logic [31:0] in_rs_val = '0, in_rt_val = '0;
    logic [15:0] in_imm = '0;
    logic        in_use_imm = 1'b0, in_imm_signed = 1'b0;
    logic [31:0] alu_a, alu_b, alu_out;
    logic [4:0]  alu_sel;
    logic        alu_carry;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_result;
    logic        out_carry;
    logic [4:0]  out_rd;
    logic [1:0]  dbg_state;

    alu_issue_stage #(.MULDIV_LAT(LAT)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_rs(in_rs), .in_rt(in_rt), .in_rs_val(in_rs_val), .in_rt_val(in_rt_val),
        .in_imm(in_imm), .in_use_imm(in_use_imm), .in_imm_signed(in_imm_signed),
        .in_rd(in_rd),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
        .alu_out(alu_out), .alu_carry(alu_carry),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_carry(out_carry), .out_rd(out_rd),
        .dbg_state(dbg_state)
    );

    // Behavioural ALU the stage drives; divide by zero gives junk on purpose.
    function automatic logic [31:0] alu_fn(input logic [4:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
        case (op)
            5'd0, 5'd1: return a + b;
            5'd2:       return a * b;
            5'd3:       return (b == 32'd0) ? 32'hDEAD_BEEF : a / b;
            5'd4:       return a - b;
            5'd5:       return a & b;
            5'd9:       return a | b;
            default:    return a ^ b;
        endcase
    endfunction

    function automatic logic carry_fn(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[32];
    endfunction

    always_comb begin
        alu_out   = alu_fn(alu_sel, alu_a, alu_b);
        alu_carry = carry_fn(alu_a, alu_b);
    end

    // ---------------- scoreboard bookkeeping ----------------
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic [4:0] op, input logic [4:0] rs, input logic [31:0] rs_val,
                          input logic [4:0] rt, input logic [31:0] rt_val, input logic [15:0] imm,
                          input logic use_imm, input logic imm_signed, input logic [4:0] rd);
        in_op = op; in_rs = rs; in_rs_val = rs_val; in_rt = rt; in_rt_val = rt_val;
        in_imm = imm; in_use_imm = use_imm; in_imm_signed = imm_signed; in_rd = rd;
        in_valid = 1'b1;
    endtask

    // Waits (bounded) for the handshake, returns just after the accepting edge.
    task automatic wait_accept(input string name);
        int n;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_accept"}, {31'd0, in_ready}, 32'd1);
        step();
        in_valid = 1'b0;
    endtask

    // Called just after the accepting edge; counts cycles until out_valid.
    task automatic wait_result(input string name, input logic [31:0] res, input logic c,
                               input logic [4:0] rd, input int lat_exp, input logic [4:0] sel);
        int lat;
        lat = 1;
        @(negedge clk);
        chk({name, "_sel"}, {27'd0, alu_sel}, {27'd0, sel});
        while (!out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk({name, "_latency"}, lat, lat_exp);
        chk({name, "_result"}, out_result, res);
        chk({name, "_carry"}, {31'd0, out_carry}, {31'd0, c});
        chk({name, "_rd"}, {27'd0, out_rd}, {27'd0, rd});
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [15:0] imm;
        logic        use_imm;
        logic        imm_signed;
        logic [4:0]  rd;
        logic [31:0] exp_res;
        logic        exp_c;
        int          exp_lat;
    } vec_t;

    vec_t vecs[11];

    // ---------------- randomized phase: model + monitor ----------------
    logic [37:0] exp_q[$];  // {carry, rd, result}
    logic        mon_en = 1'b0;
    logic        m_live = 1'b0;
    logic [4:0]  m_rd = '0;
    logic [31:0] m_res = '0;
    logic        prev_hold = 1'b0;
    logic [31:0] prev_res = '0;
    logic        prev_c = 1'b0;
    logic [4:0]  prev_rd = '0;
    int          wait_cnt = 0;

    always @(negedge clk) begin
        logic        live0;
        logic [31:0] a, b, r;
        logic        c;
        logic [37:0] e;
        if (mon_en) begin
            live0 = m_live;
            if (prev_hold) begin
                chk("hold_result", out_result, prev_res);
                chk("hold_carry_rd", {26'd0, out_carry, out_rd}, {26'd0, prev_c, prev_rd});
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_result", {31'd0, out_valid}, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("rand_result", out_result, e[31:0]);
                    chk("rand_carry_rd", {26'd0, out_carry, out_rd}, {26'd0, e[37], e[36:32]});
                end
                m_live = 1'b0;
            end
            if (in_valid && in_ready) begin
                a = (live0 && m_rd == in_rs && in_rs != 5'd0) ? m_res : in_rs_val;
                if (in_use_imm)
                    b = in_imm_signed ? {{16{in_imm[15]}}, in_imm} : {16'b0, in_imm};
                else
                    b = (live0 && m_rd == in_rt && in_rt != 5'd0) ? m_res : in_rt_val;
                if (in_op == 5'd3 && b == 32'd0) begin
                    r = 32'hFFFF_FFFF;
                    c = 1'b0;
                end else begin
                    r = alu_fn(in_op, a, b);
                    c = carry_fn(a, b);
                end
                exp_q.push_back({c, in_rd, r});
                m_live = 1'b1;
                m_rd   = in_rd;
                m_res  = r;
            end
            if (exp_q.size() > 0 && !out_valid) wait_cnt++;
            else wait_cnt = 0;
            if (wait_cnt > LAT + 2) begin
                chk("rand_capture_timeout", wait_cnt, LAT + 2);
                wait_cnt = 0;
            end
            prev_hold = out_valid && !out_ready;
            prev_res  = out_result;
            prev_c    = out_carry;
            prev_rd   = out_rd;
        end
    end

    task automatic rand_op();
        logic [4:0] ops[8];
        ops = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd9, 5'd16};
        in_op = ops[$urandom_range(0, 7)];
        if (in_op == 5'd16) in_op = 5'($urandom_range(16, 31));
        in_rs         = 5'($urandom_range(0, 3));
        in_rt         = 5'($urandom_range(0, 3));
        in_rd         = 5'($urandom_range(0, 3));
        in_rs_val     = $urandom();
        in_rt_val     = ($urandom_range(0, 3) == 0) ? 32'd0 : 32'($urandom_range(0, 1000));
        in_imm        = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom());
        in_use_imm    = 1'($urandom_range(0, 1));
        in_imm_signed = 1'($urandom_range(0, 1));
        in_valid      = 1'b1;
    endtask

    // ---------------- main test ----------------
    initial begin
        logic seen;
        logic acc;

        vecs[0]  = '{5'd0,  32'd5,          32'd0,          16'hFFFF, 1'b1, 1'b1, 5'd1, 32'd4,          1'b1, 2};
        vecs[1]  = '{5'd0,  32'd5,          32'd0,          16'hFFFF, 1'b1, 1'b0, 5'd2, 32'h0001_0004,  1'b0, 2};
        vecs[2]  = '{5'd0,  32'hFFFF_FFFF,  32'd1,          16'h0,    1'b0, 1'b0, 5'd3, 32'd0,          1'b1, 2};
        vecs[3]  = '{5'd2,  32'd7,          32'd6,          16'h0,    1'b0, 1'b0, 5'd4, 32'd42,         1'b0, LAT + 1};
        vecs[4]  = '{5'd3,  32'd100,        32'd7,          16'h0,    1'b0, 1'b0, 5'd5, 32'd14,         1'b0, LAT + 1};
        vecs[5]  = '{5'd3,  32'd100,        32'd0,          16'h0,    1'b0, 1'b0, 5'd6, 32'hFFFF_FFFF,  1'b0, 2};
        vecs[6]  = '{5'd3,  32'hFFFF_FFFF,  32'd9,          16'h0,    1'b1, 1'b1, 5'd7, 32'hFFFF_FFFF,  1'b0, 2};
        vecs[7]  = '{5'd3,  32'd100,        32'd0,          16'hFFFE, 1'b1, 1'b1, 5'd8, 32'd0,          1'b1, LAT + 1};
        vecs[8]  = '{5'd21, 32'hF0F0_F0F0,  32'h0F0F_0F0F,  16'h0,    1'b0, 1'b0, 5'd9, 32'hFFFF_FFFF,  1'b0, 2};
        vecs[9]  = '{5'd31, 32'h8000_0000,  32'h8000_0000,  16'h0,    1'b0, 1'b0, 5'd10, 32'd0,         1'b1, 2};
        vecs[10] = '{5'd9,  32'd10,         32'd0,          16'h8000, 1'b1, 1'b0, 5'd11, 32'h0000_800A, 1'b0, 2};

        // Reset state
        rst = 1'b1;
        step();
        step();
        @(negedge clk);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_alu_a", alu_a, 32'd0);
        chk("rst_alu_b", alu_b, 32'd0);
        chk("rst_alu_sel", {27'd0, alu_sel}, 32'd0);
        chk("rst_out", {26'd0, out_carry, out_rd}, 32'd0);
        chk("rst_out_result", out_result, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Table-driven single operations, no forwarding (rs = rt = 0)
        out_ready = 1'b1;
        for (int i = 0; i < 11; i++) begin
            set_op(vecs[i].op, 5'd0, vecs[i].a, 5'd0, vecs[i].b, vecs[i].imm,
                   vecs[i].use_imm, vecs[i].imm_signed, vecs[i].rd);
            wait_accept($sformatf("vec%0d", i));
            wait_result($sformatf("vec%0d", i), vecs[i].exp_res, vecs[i].exp_c,
                        vecs[i].rd, vecs[i].exp_lat, vecs[i].op);
            step();
        end

        // Forwarding from a held result, with backpressure
        out_ready = 1'b0;
        set_op(5'd1, 5'd0, 32'd4, 5'd0, 32'd6, 16'h0, 1'b0, 1'b0, 5'd3);
        wait_accept("fwd_src");
        wait_result("fwd_src", 32'd10, 1'b0, 5'd3, 2, 5'd1);
        step();
        set_op(5'd9, 5'd3, 32'd0, 5'd0, 32'd0, 16'h8000, 1'b1, 1'b0, 5'd5);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
            chk("bp_hold", {26'd0, out_valid, out_rd}, {26'd0, 1'b1, 5'd3});
            chk("bp_result", out_result, 32'd10);
        end
        step();
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_ready", {31'd0, in_ready}, 32'd1);
        step();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        wait_result("fwd_or", 32'h0000_800A, 1'b0, 5'd5, 2, 5'd9);
        chk("fwd_alu_a", alu_a, 32'd10);
        chk("fwd_alu_b", alu_b, 32'h0000_8000);

        // Forwarding while the source result drains on the accepting edge
        step();
        out_ready = 1'b1;
        set_op(5'd0, 5'd5, 32'd0, 5'd0, 32'd0, 16'h0001, 1'b1, 1'b1, 5'd0);
        wait_accept("fwd_drain");
        out_ready = 1'b0;
        wait_result("fwd_drain", 32'h0000_800B, 1'b0, 5'd0, 2, 5'd0);

        // Register 0 is never forwarded, even with out_rd == 0 held
        step();
        out_ready = 1'b1;
        set_op(5'd0, 5'd0, 32'd7, 5'd0, 32'd9, 16'h0, 1'b0, 1'b0, 5'd2);
        wait_accept("r0");
        wait_result("r0", 32'd16, 1'b0, 5'd2, 2, 5'd0);
        chk("r0_alu_a", alu_a, 32'd7);
        chk("r0_alu_b", alu_b, 32'd9);

        // Multiply: operands held for LAT cycles while inputs wiggle
        step();
        set_op(5'd2, 5'd0, 32'd7, 5'd0, 32'd6, 16'h0, 1'b0, 1'b0, 5'd4);
        wait_accept("mul");
        for (int k = 0; k < LAT; k++) begin
            in_rs_val = $urandom();
            in_rt_val = $urandom();
            in_valid  = 1'b1;
            @(negedge clk);
            chk("mul_hold_sel", {27'd0, alu_sel}, 32'd2);
            chk("mul_hold_a", alu_a, 32'd7);
            chk("mul_hold_b", alu_b, 32'd6);
            chk("mul_busy", {30'd0, in_ready, out_valid}, 32'd0);
            step();
        end
        @(negedge clk);
        chk("mul_valid", {31'd0, out_valid}, 32'd1);
        chk("mul_result", out_result, 32'd42);
        in_valid = 1'b0;

        // Reset in the middle of a multiply
        step();
        out_ready = 1'b0;
        set_op(5'd2, 5'd0, 32'd3, 5'd0, 32'd3, 16'h0, 1'b0, 1'b0, 5'd6);
        wait_accept("rst_mul");
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("rstmul_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rstmul_alu", alu_a | alu_b | {27'd0, alu_sel}, 32'd0);
        chk("rstmul_in_ready", {31'd0, in_ready}, 32'd1);
        seen = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        chk("rstmul_no_stale", {31'd0, seen}, 32'd0);

        // Randomized traffic against the transaction model
        step();
        out_ready = 1'b1;
        exp_q.delete();
        m_live = 1'b0;
        mon_en = 1'b1;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            @(negedge clk);
            acc = in_valid && in_ready;
            step();
            out_ready = ($urandom_range(0, 9) < 7);
            if (!in_valid || acc) begin
                if ($urandom_range(0, 3) != 0) rand_op();
                else in_valid = 1'b0;
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (30) step();
        @(negedge clk);
        mon_en = 1'b0;
        chk("rand_queue_empty", exp_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
